// File: rtl/mont_pkg.sv
// Shared constants and types for the Curve25519-field Montgomery exponentiator.
// p = 2^255-19, R = 2^255.
package mont_pkg;

  localparam int MONT_W = 255;

  localparam logic [MONT_W-1:0] P       = {MONT_W{1'b1}} - MONT_W'(18);
  localparam logic [MONT_W-1:0] R_MONT  = MONT_W'(19);
  localparam logic [MONT_W-1:0] R2_MONT = MONT_W'(361);

  typedef enum logic [2:0] {
    IDLE,
    TOMONT,
    SQR,
    MUL,
    FROMMONT,
    DONE
  } state_t;

  function automatic logic [MONT_W-1:0] red_p(input logic [MONT_W-1:0] v);
    return (v >= P) ? v - P : v;
  endfunction

endpackage

// File: rtl/mont_mul_core.sv
// Bit-serial Montgomery multiplier: r = a*b*2^-255 mod p, one bit of a per cycle.
// Loaded by i_start; o_done pulses after MONT_W iterations.
module mont_mul_core
  import mont_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [MONT_W-1:0] i_a,
  input  logic [MONT_W-1:0] i_b,
  output logic              o_done,
  output logic [MONT_W-1:0] o_r
);

  localparam int CW = $clog2(MONT_W);

  logic [MONT_W-1:0] r_a;
  logic [MONT_W-1:0] r_b;
  logic [MONT_W:0]   r_u;
  logic [CW-1:0]     r_cnt;
  logic              r_run;
  logic              r_done;

  logic [MONT_W+1:0] w_t;
  logic [MONT_W+1:0] w_s;
  logic [MONT_W-1:0] w_red;

  always_comb begin
    w_t = {1'b0, r_u} + (r_a[0] ? {2'b00, r_b} : '0);
    w_s = w_t + (w_t[0] ? {2'b00, P} : '0);
    // Output is reduced below p so it can be fed back as a 255-bit operand.
    w_red = (r_u >= {1'b0, P}) ? MONT_W'(r_u - {1'b0, P})
                               : r_u[MONT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_u    <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_a   <= i_a;
        r_b   <= i_b;
        r_u   <= '0;
        r_cnt <= '0;
        r_run <= 1'b1;
      end else if (r_run) begin
        r_u   <= (MONT_W+1)'(w_s >> 1);
        r_a   <= r_a >> 1;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(MONT_W-1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_r    = w_red;

endmodule

// File: rtl/mont_exp_ctrl.sv
// Constant-time square-and-always-multiply x^e mod p sequencer.
// Owns the single Montgomery multiplier and its operand muxing.
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_W,
  parameter int EXP_W = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [EXP_W-1:0] e,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  state_t r_state;
  state_t w_next;

  logic [MONT_W-1:0] r_x;
  logic [MONT_W-1:0] r_xm;
  logic [MONT_W-1:0] r_acc;
  logic [MONT_W-1:0] r_result;
  logic [EXP_W-1:0]  r_e;
  logic [IW-1:0]     r_idx;
  logic              r_bit;
  logic              r_issued;

  logic [MONT_W-1:0] w_a;
  logic [MONT_W-1:0] w_b;
  logic [MONT_W-1:0] w_r;
  logic              w_op;
  logic              w_mm_start;
  logic              w_mm_done;

  always_comb begin
    w_next = r_state;
    w_a    = r_acc;
    w_b    = r_acc;
    w_op   = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_next = TOMONT;
      TOMONT: begin
        w_op = 1'b1;
        w_a  = r_x;
        w_b  = R2_MONT;
        if (w_mm_done) w_next = SQR;
      end
      SQR: begin
        w_op = 1'b1;
        if (w_mm_done) w_next = MUL;
      end
      MUL: begin
        w_op = 1'b1;
        w_b  = r_xm;
        if (w_mm_done) w_next = (r_idx == '0) ? FROMMONT : SQR;
      end
      FROMMONT: begin
        w_op = 1'b1;
        w_b  = MONT_W'(1);
        if (w_mm_done) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_mm_start = w_op & ~r_issued;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_e      <= '0;
      r_idx    <= '0;
      r_xm     <= '0;
      r_acc    <= '0;
      r_bit    <= 1'b0;
      r_issued <= 1'b0;
      r_result <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_x   <= x;
        r_e   <= e;
        r_idx <= IW'(EXP_W-1);
      end
      if (w_mm_start)     r_issued <= 1'b1;
      else if (w_mm_done) r_issued <= 1'b0;
      // Multiply always runs; the exponent bit only decides whether to keep it.
      if (w_mm_start && r_state == MUL) r_bit <= r_e[r_idx];
      if (w_mm_done) begin
        unique case (r_state)
          TOMONT: begin
            r_xm  <= w_r;
            r_acc <= R_MONT;
          end
          SQR: r_acc <= w_r;
          MUL: begin
            if (r_bit) r_acc <= w_r;
            if (r_idx != '0) r_idx <= r_idx - 1'b1;
          end
          FROMMONT: r_result <= red_p(w_r);
          default: ;
        endcase
      end
    end
  end

  mont_mul_core u_core (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_mm_start),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_done  (w_mm_done),
    .o_r     (w_r)
  );

  assign ready  = (r_state == IDLE);
  assign busy   = ~ready;
  assign done   = (r_state == DONE);
  assign result = r_result;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboard bench for mont_exp_ctrl with an 8-bit exponent.
// Expected results come from constants or a shift-add modexp model.
module tb_mont_exp_ctrl;

  localparam int W   = 255;
  localparam int EW  = 8;
  localparam int OPC = W + 2;
  localparam int LAT = (2*EW + 2) * OPC;
  localparam logic [W-1:0] PM = {W{1'b1}} - W'(18);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  x = '0;
  logic [EW-1:0] e = '0;
  logic          ready;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;

  mont_exp_ctrl #(.WIDTH(W), .EXP_W(EW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x      (x),
    .e      (e),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int last_lat = 0;

  typedef struct {
    logic [W-1:0] res;
    int           acc;
    string        tag;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0] r;
    r = '0;
    for (int i = W-1; i >= 0; i--) begin
      r = r << 1;
      if (r >= {1'b0, PM}) r = r - {1'b0, PM};
      if (b[i]) begin
        r = r + {1'b0, a};
        if (r >= {1'b0, PM}) r = r - {1'b0, PM};
      end
    end
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] modexp(input logic [W-1:0] xi,
                                          input logic [EW-1:0] ei);
    logic [W-1:0] bs;
    logic [W-1:0] r;
    bs = (xi >= PM) ? xi - PM : xi;
    r  = W'(1);
    for (int i = EW-1; i >= 0; i--) begin
      r = mulmod(r, r);
      if (ei[i]) r = mulmod(r, bs);
    end
    return r;
  endfunction

  always @(negedge clk) begin : mon
    exp_t t;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", W'(sb.size()), W'(1));
      end else begin
        t = sb.pop_front();
        last_lat = cyc - t.acc;
        check({t.tag, "_res"}, result, t.res);
        check({t.tag, "_lat"}, W'(last_lat), W'(LAT));
      end
      n_done++;
    end
  end

  task automatic start_op(input logic [W-1:0] xi, input logic [EW-1:0] ei,
                          input logic [W-1:0] ex, input string tag);
    exp_t t;
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (ready !== 1'b1) check({tag, "_ready_wait"}, W'(ready), W'(1));
    x = xi;
    e = ei;
    start = 1'b1;
    t.res = ex;
    t.acc = cyc + 1;
    t.tag = tag;
    sb.push_back(t);
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n0;
    int k;
    n0 = n_done;
    k = 0;
    while (n_done == n0 && k < LAT + 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({tag, "_finished"}, W'(n_done - n0), W'(1));
    @(negedge clk);
    #1;
    check({tag, "_done_pulse"}, W'(done), W'(0));
    check({tag, "_ready_after"}, W'(ready), W'(1));
  endtask

  task automatic do_op(input logic [W-1:0] xi, input logic [EW-1:0] ei,
                       input logic [W-1:0] ex, input string tag);
    start_op(xi, ei, ex, tag);
    wait_done(tag);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] rnd;
    logic [W-1:0] xr;
    logic [EW-1:0] er;
    int l0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", W'(ready), W'(1));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_result", result, W'(0));
    rst = 1'b0;
    @(negedge clk);
    #1;

    do_op(W'(2), 8'd3, W'(8), "x2e3");
    do_op(W'(5), 8'd0, W'(1), "x5e0");
    do_op(W'(0), 8'd0, W'(1), "x0e0");
    do_op(W'(0), 8'd5, W'(0), "x0e5");
    do_op(W'(7), 8'd1, W'(7), "x7e1");
    do_op(PM - W'(1), 8'd2, W'(1), "pm1e2");
    do_op(PM + W'(3), 8'd2, W'(9), "pp3e2");

    do_op(W'(9), 8'h00, W'(1), "lat_e00");
    l0 = last_lat;
    do_op(W'(9), 8'hFF, modexp(W'(9), 8'hFF), "lat_eff");
    check("lat_equal", W'(last_lat), W'(l0));

    start_op(W'(3), 8'd4, W'(81), "mid");
    repeat (1000) @(negedge clk);
    #1;
    check("mid_busy", W'(busy), W'(1));
    check("mid_ready", W'(ready), W'(0));
    x = W'(5);
    e = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("mid_busy2", W'(busy), W'(1));
    wait_done("mid");
    check("mid_sb_empty", W'(sb.size()), W'(0));

    start_op(W'(2), 8'd5, W'(32), "abort");
    repeat (2000) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("abort_ready", W'(ready), W'(1));
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_result", result, W'(0));
    void'(sb.pop_back());
    rst = 1'b0;
    @(negedge clk);
    #1;
    do_op(W'(3), 8'd5, W'(243), "after_abort");

    for (int i = 0; i < 3; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      xr = rnd[W-1:0];
      er = EW'($urandom_range(0, 255));
      do_op(xr, er, modexp(xr, er), "rand");
    end

    check("final_sb_empty", W'(sb.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
